strength_bus_resolver: RTL and testbench

- N-driver shared-bus resolver: per-driver, per-value drive strengths (separate strength for driving 1 and for driving 0); resolves each bit with Verilog-style strength rules.
- Resolved bus is registered; contention events are counted and the first one is captured.
- Used as a synthesizable model of multi-driver nets in lab designs, and for contention checking on shared buses.

---
 rtl/strength_bus_resolver.sv | 106 ++++++++++
 tb/tb_strength_bus_resolver.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/strength_bus_resolver.sv
// strength_bus_resolver: strength-based N-driver bus resolution with registered result and contention capture
module strength_bus_resolver #(
    parameter int N = 4,
    parameter int W = 8,
    parameter int MODE = 0,
    parameter int CNT_W = 8,
    localparam int BW = (W > 1) ? $clog2(W) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     drv_en,
    input  logic [N*W-1:0]   drv_val,
    input  logic [2*N-1:0]   drv_s1,
    input  logic [2*N-1:0]   drv_s0,
    input  logic             clr,
    output logic [W-1:0]     bus_val,
    output logic [W-1:0]     bus_z,
    output logic [W-1:0]     bus_x,
    output logic             conflict,
    output logic [CNT_W-1:0] conflict_cnt,
    output logic             first_valid,
    output logic [BW-1:0]    first_bit,
    output logic [N-1:0]     first_mask
);

    if (MODE < 0 || MODE > 2 || N < 2) begin : g_bad_params
        $error("strength_bus_resolver: invalid MODE or N");
    end

    typedef enum logic {IDLE, CAPTURED} state_t;

    state_t         state;
    logic [W-1:0]   nv, nz, nx;
    logic [BW-1:0]  nbit;
    logic [N-1:0]   nmask;
    logic [1:0]     smax;
    logic           h1, h0;

    function automatic logic [1:0] str(input int i, input int b);
        return drv_en[i] ? (drv_val[i*W+b] ? drv_s1[2*i+:2] : drv_s0[2*i+:2]) : 2'd0;
    endfunction

    // Bits are walked high to low so the lowest conflicting bit is the last to write nbit/nmask.
    always_comb begin
        nv = '0;
        nz = '0;
        nx = '0;
        nbit = '0;
        nmask = '0;
        smax = 2'd0;
        h1 = 1'b0;
        h0 = 1'b0;
        for (int b = W - 1; b >= 0; b--) begin
            smax = 2'd0;
            for (int i = 0; i < N; i++) smax = (str(i, b) > smax) ? str(i, b) : smax;
            h1 = 1'b0;
            h0 = 1'b0;
            for (int i = 0; i < N; i++) begin
                h1 = h1 | ((smax != 2'd0) && (str(i, b) == smax) && drv_val[i*W+b]);
                h0 = h0 | ((smax != 2'd0) && (str(i, b) == smax) && !drv_val[i*W+b]);
            end
            nz[b] = smax == 2'd0;
            nx[b] = (MODE == 0) && h1 && h0;
            nv[b] = (MODE == 1) ? h1 : (h1 && !h0);
            if (nx[b]) begin
                nbit = BW'(b);
                for (int i = 0; i < N; i++) nmask[i] = str(i, b) == smax;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_val <= '0;
            bus_z <= '1;
            bus_x <= '0;
            conflict <= 1'b0;
            conflict_cnt <= '0;
            first_valid <= 1'b0;
            first_bit <= '0;
            first_mask <= '0;
            state <= IDLE;
        end else begin
            bus_val <= nv;
            bus_z <= nz;
            bus_x <= nx;
            conflict <= |nx;
            if (clr) begin
                conflict_cnt <= '0;
                first_valid <= 1'b0;
                first_bit <= '0;
                first_mask <= '0;
                state <= IDLE;
            end else if (|nx) begin
                if (conflict_cnt != '1) conflict_cnt <= conflict_cnt + CNT_W'(1);
                if (state == IDLE) begin
                    state <= CAPTURED;
                    first_valid <= 1'b1;
                    first_bit <= nbit;
                    first_mask <= nmask;
                end
            end
        end
    end

endmodule

// File: tb/tb_strength_bus_resolver.sv
// tb_strength_bus_resolver: five resolver configurations checked each cycle against a strength-histogram model
module tb_strength_bus_resolver;

    logic clk = 0, rst = 1, clr = 0;
    always #5 clk = ~clk;

    logic [1:0]  en0, val0;
    logic [3:0]  s10, s00;
    logic [3:0]  en;
    logic [31:0] val;
    logic [7:0]  s1, s0;
    int checks = 0, errors = 0;
    logic go = 0;

    logic [7:0] o_val [5], o_z [5], o_x [5], o_cnt [5];
    logic       o_cf [5], o_fv [5];
    logic [2:0] o_fb [5];
    logic [3:0] o_fm [5];

    logic v0, z0, x0, cf0, fv0, fb0;
    logic [7:0] c0;
    logic [1:0] fm0;

    strength_bus_resolver #(.N(2), .W(1), .MODE(0), .CNT_W(8)) d0 (
        .clk(clk), .rst(rst), .drv_en(en0), .drv_val(val0), .drv_s1(s10), .drv_s0(s00), .clr(clr),
        .bus_val(v0), .bus_z(z0), .bus_x(x0), .conflict(cf0), .conflict_cnt(c0),
        .first_valid(fv0), .first_bit(fb0), .first_mask(fm0)
    );
    assign o_val[0] = {7'b0, v0};
    assign o_z[0] = {7'b0, z0};
    assign o_x[0] = {7'b0, x0};
    assign o_cf[0] = cf0;
    assign o_cnt[0] = c0;
    assign o_fv[0] = fv0;
    assign o_fb[0] = {2'b0, fb0};
    assign o_fm[0] = {2'b0, fm0};

    for (genvar g = 1; g < 5; g++) begin : gd
        localparam int MD = g == 2 ? 1 : g == 3 ? 2 : 0;
        localparam int CW = g == 4 ? 2 : 8;
        logic [7:0] bv, bz, bx;
        logic cf, fv;
        logic [CW-1:0] c;
        logic [2:0] fb;
        logic [3:0] fm;
        strength_bus_resolver #(.N(4), .W(8), .MODE(MD), .CNT_W(CW)) dut (
            .clk(clk), .rst(rst), .drv_en(en), .drv_val(val), .drv_s1(s1), .drv_s0(s0), .clr(clr),
            .bus_val(bv), .bus_z(bz), .bus_x(bx), .conflict(cf), .conflict_cnt(c),
            .first_valid(fv), .first_bit(fb), .first_mask(fm)
        );
        assign o_val[g] = bv;
        assign o_z[g] = bz;
        assign o_x[g] = bx;
        assign o_cf[g] = cf;
        assign o_cnt[g] = 8'(c);
        assign o_fv[g] = fv;
        assign o_fb[g] = fb;
        assign o_fm[g] = fm;
    end

    // Per bit: histogram of driven ones/zeros by strength level; the highest populated level decides.
    function automatic void resolve(input int n, input int w, input int mode, input logic [3:0] e,
                                    input logic [31:0] dv, input logic [7:0] p1, input logic [7:0] p0,
                                    output logic [7:0] v, output logic [7:0] z, output logic [7:0] x,
                                    output int fb, output logic [3:0] fm);
        int ones [4];
        int zeros [4];
        int s [4];
        int top;
        logic bv, got;
        v = '0; z = '0; x = '0; fb = 0; fm = '0; got = 0;
        for (int b = 0; b < w; b++) begin
            ones = '{default: 0};
            zeros = '{default: 0};
            s = '{default: 0};
            for (int i = 0; i < n; i++) begin
                bv = dv[i*w+b];
                s[i] = !e[i] ? 0 : bv ? int'(p1[2*i+:2]) : int'(p0[2*i+:2]);
                if (bv) ones[s[i]]++;
                else zeros[s[i]]++;
            end
            top = 0;
            for (int l = 1; l < 4; l++) if (ones[l] + zeros[l] > 0) top = l;
            if (top == 0) z[b] = 1'b1;
            else if (zeros[top] == 0) v[b] = 1'b1;
            else if (ones[top] > 0) begin
                if (mode == 0) x[b] = 1'b1;
                else if (mode == 1) v[b] = 1'b1;
            end
            if (x[b] && !got) begin
                got = 1'b1;
                fb = b;
                for (int i = 0; i < n; i++) fm[i] = s[i] == top;
            end
        end
    endfunction

    logic [7:0] r_v [5], r_z [5], r_x [5];
    int         r_fb [5];
    logic [3:0] r_fm [5];
    logic [7:0] tv, tz, tx;
    int         tfb;
    logic [3:0] tfm;

    always_comb begin
        tv = '0; tz = '0; tx = '0; tfb = 0; tfm = '0;
        for (int k = 0; k < 5; k++) begin
            resolve(k == 0 ? 2 : 4, k == 0 ? 1 : 8, k == 2 ? 1 : k == 3 ? 2 : 0,
                    k == 0 ? {2'b0, en0} : en, k == 0 ? {30'b0, val0} : val,
                    k == 0 ? {4'b0, s10} : s1, k == 0 ? {4'b0, s00} : s0, tv, tz, tx, tfb, tfm);
            r_v[k] = tv; r_z[k] = tz; r_x[k] = tx; r_fb[k] = tfb; r_fm[k] = tfm;
        end
    end

    logic [7:0] m_val [5], m_z [5], m_x [5];
    logic       m_cf [5], m_fv [5];
    int         m_cnt [5], m_fb [5];
    logic [3:0] m_fm [5];

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 5; k++) begin
            if (rst) begin
                m_val[k] <= 0; m_z[k] <= (k == 0) ? 8'h01 : 8'hFF; m_x[k] <= 0; m_cf[k] <= 0;
                m_cnt[k] <= 0; m_fv[k] <= 0; m_fb[k] <= 0; m_fm[k] <= 0;
            end else begin
                m_val[k] <= r_v[k]; m_z[k] <= r_z[k]; m_x[k] <= r_x[k]; m_cf[k] <= r_x[k] != 0;
                if (clr) begin
                    m_cnt[k] <= 0; m_fv[k] <= 0; m_fb[k] <= 0; m_fm[k] <= 0;
                end else if (r_x[k] != 0) begin
                    if (m_cnt[k] < ((k == 4) ? 3 : 255)) m_cnt[k] <= m_cnt[k] + 1;
                    if (!m_fv[k]) begin
                        m_fv[k] <= 1; m_fb[k] <= r_fb[k]; m_fm[k] <= r_fm[k];
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input int k, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s dut%0d got %0h want %0h at %0t", nm, k, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        if (go) begin
            for (int k = 0; k < 5; k++) begin
                chk("val", k, 32'(o_val[k]), 32'(m_val[k]));
                chk("z", k, 32'(o_z[k]), 32'(m_z[k]));
                chk("x", k, 32'(o_x[k]), 32'(m_x[k]));
                chk("conflict", k, 32'(o_cf[k]), 32'(m_cf[k]));
                chk("cnt", k, 32'(o_cnt[k]), m_cnt[k]);
                chk("first_valid", k, 32'(o_fv[k]), 32'(m_fv[k]));
                chk("first_bit", k, 32'(o_fb[k]), m_fb[k]);
                chk("first_mask", k, 32'(o_fm[k]), 32'(m_fm[k]));
            end
        end
    end

    task automatic setab(input logic a, input logic b);
        en0 = 2'b11;
        val0 = {a & b, a | b};
        s10 = 4'b1011;
        s00 = 4'b1110;
    endtask

    initial begin
        en0 = 0; val0 = 0; s10 = 0; s00 = 0; en = 0; val = 0; s1 = 0; s0 = 0;
        repeat (2) @(negedge clk);
        go = 1;
        chk("rst_z", 1, 32'(o_z[1]), 'hFF);
        chk("rst_z", 0, 32'(o_z[0]), 1);
        chk("rst_cnt", 1, 32'(o_cnt[1]), 0);
        rst = 0;
        setab(0, 0);
        @(posedge clk); #2;
        chk("ab00", 0, 32'(o_val[0]), 0);
        chk("all_off_z", 1, 32'(o_z[1]), 'hFF);
        @(negedge clk);
        setab(1, 1);
        en = 4'b0100; val[23:16] = 8'hA5; s1[5:4] = 2'd1; s0[5:4] = 2'd1;
        @(posedge clk); #2;
        chk("ab11", 0, 32'(o_val[0]), 1);
        chk("weak_a5", 1, 32'(o_val[1]), 'hA5);
        chk("weak_z", 1, 32'(o_z[1]), 0);
        @(negedge clk);
        setab(0, 1);
        en = 4'b1100; val[31:24] = 8'h0F; s1[7:6] = 2'd2; s0[7:6] = 2'd2;
        @(posedge clk); #2;
        chk("ab01_x", 0, 32'(o_x[0]), 1);
        chk("ab01_cf", 0, 32'(o_cf[0]), 1);
        chk("strong_0f", 1, 32'(o_val[1]), 'h0F);
        @(negedge clk);
        setab(1, 0);
        @(posedge clk); #2;
        chk("ab10_x", 0, 32'(o_x[0]), 1);
        chk("ab10_cf", 0, 32'(o_cf[0]), 1);
        @(negedge clk);
        clr = 1; setab(0, 0);
        @(negedge clk);
        clr = 0; setab(0, 1);
        repeat (3) @(posedge clk); #2;
        chk("hold_cnt", 0, 32'(o_cnt[0]), 3);
        chk("hold_fv", 0, 32'(o_fv[0]), 1);
        chk("hold_fb", 0, 32'(o_fb[0]), 0);
        chk("hold_fm", 0, 32'(o_fm[0]), 'h3);
        @(negedge clk);
        clr = 1; setab(0, 0);
        @(posedge clk); #2;
        chk("clr_cnt", 0, 32'(o_cnt[0]), 0);
        chk("clr_fv", 0, 32'(o_fv[0]), 0);
        chk("clr_fm", 0, 32'(o_fm[0]), 0);
        chk("clr_cf", 0, 32'(o_cf[0]), 0);
        @(negedge clk);
        clr = 0;
        en = 4'b0011; val = {16'h0, 8'h3C, 8'hF0}; s1 = 8'b00001010; s0 = 8'b00001010;
        repeat (6) @(posedge clk); #2;
        chk("wor", 2, 32'(o_val[2]), 'hFC);
        chk("wand", 3, 32'(o_val[3]), 'h30);
        chk("wor_cnt", 2, 32'(o_cnt[2]), 0);
        chk("wand_cnt", 3, 32'(o_cnt[3]), 0);
        chk("wor_fv", 2, 32'(o_fv[2]), 0);
        chk("sat_cnt", 4, 32'(o_cnt[4]), 3);
        chk("wire_cnt", 1, 32'(o_cnt[1]), 6);
        chk("wire_x", 1, 32'(o_x[1]), 'hCC);
        chk("wire_fb", 1, 32'(o_fb[1]), 2);
        chk("wire_fm", 1, 32'(o_fm[1]), 'h3);
        @(negedge clk);
        clr = 1;
        @(posedge clk); #2;
        chk("clr_conf_cnt", 4, 32'(o_cnt[4]), 0);
        chk("clr_conf_fv", 4, 32'(o_fv[4]), 0);
        chk("clr_conf_cf", 4, 32'(o_cf[4]), 1);
        @(negedge clk);
        clr = 0;
        for (int t = 0; t < 3000; t++) begin
            en = 4'($urandom); val = $urandom; s1 = 8'($urandom); s0 = 8'($urandom);
            en0 = 2'($urandom); val0 = 2'($urandom); s10 = 4'($urandom); s00 = 4'($urandom);
            clr = $urandom_range(0, 19) == 0;
            if ($urandom_range(0, 99) == 0) begin
                #($urandom_range(1, 3));
                rst = 1;
                #1;
                chk("arst_val", 1, 32'(o_val[1]), 0);
                chk("arst_z", 1, 32'(o_z[1]), 'hFF);
                chk("arst_x", 1, 32'(o_x[1]), 0);
                chk("arst_cf", 1, 32'(o_cf[1]), 0);
                chk("arst_cnt", 1, 32'(o_cnt[1]), 0);
                chk("arst_fv", 1, 32'(o_fv[1]), 0);
                chk("arst_fb", 1, 32'(o_fb[1]), 0);
                chk("arst_fm", 1, 32'(o_fm[1]), 0);
                chk("arst_z", 0, 32'(o_z[0]), 1);
            end
            @(negedge clk);
            rst = 0;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
